// File: rtl/gpio_port_if.sv
// Bus bundle for gpio_port: write strobe, target/op select, data in/out and the
// physical output pins.
interface gpio_port_if #(
  parameter int LED_W  = 8,
  parameter int CS_W   = 2,
  parameter int GPIO_W = 22
);
  logic              EN;
  logic [1:0]        SEL;
  logic [1:0]        OP;
  logic [31:0]       PData_in;
  logic [31:0]       PData_out;
  logic [CS_W-1:0]   counter_set;
  logic [LED_W-1:0]  LED_out;
  logic [GPIO_W-1:0] GPIOf0;

  modport master (
    output EN, SEL, OP, PData_in,
    input  PData_out, counter_set, LED_out, GPIOf0
  );

  modport slave (
    input  EN, SEL, OP, PData_in,
    output PData_out, counter_set, LED_out, GPIOf0
  );
endinterface

// File: rtl/gpio_port.sv
// GPIO port: packed {GPIO, LED, counter_set} register with set/clear/toggle writes,
// plus a reloadable prescaler that blinks masked active-low LEDs. Falling-edge clocked.
module gpio_port #(
  parameter int               LED_W   = 8,
  parameter int               CS_W    = 2,
  parameter int               GPIO_W  = 22,
  parameter logic [LED_W-1:0] LED_RST = LED_W'(8'h2A),
  parameter int               PRE_W   = 24
) (
  input  logic         clk,
  input  logic         rst,
  gpio_port_if.slave   bus
);

  if (LED_W + CS_W + GPIO_W != 32) begin : g_width_chk
    $error("gpio_port: LED_W + CS_W + GPIO_W must equal 32");
  end
  if (PRE_W < 1 || PRE_W > 24) begin : g_pre_chk
    $error("gpio_port: PRE_W must be within 1..24");
  end

  function automatic logic [31:0] apply_op(input logic [31:0] old_v,
                                           input logic [31:0] data_v,
                                           input logic [1:0]  op_v);
    logic [31:0] res_v;
    case (op_v)
      2'b00:   res_v = data_v;
      2'b01:   res_v = old_v | data_v;
      2'b10:   res_v = old_v & ~data_v;
      2'b11:   res_v = old_v ^ data_v;
      default: res_v = old_v;
    endcase
    return res_v;
  endfunction

  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [CS_W-1:0]   cs_q, cs_d;
  logic [LED_W-1:0]  mask_q, mask_d;
  logic [PRE_W-1:0]  reload_q, reload_d;
  logic [PRE_W-1:0]  cnt_q, cnt_d;
  logic              phase_q, phase_d;

  logic [31:0] packed_s;
  logic [31:0] wr_s;
  logic [23:0] cnt_ext_s;

  assign packed_s  = {gpio_q, led_q, cs_q};
  assign cnt_ext_s = 24'(cnt_q);

  // Register state, falling-edge clocked with asynchronous active-low reset
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      gpio_q   <= '0;
      led_q    <= LED_RST;
      cs_q     <= '0;
      mask_q   <= '0;
      reload_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
    end else begin
      gpio_q   <= gpio_d;
      led_q    <= led_d;
      cs_q     <= cs_d;
      mask_q   <= mask_d;
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

  // Next state: prescaler free-runs, then a write to the selected target overrides it
  always_comb begin
    gpio_d   = gpio_q;
    led_d    = led_q;
    cs_d     = cs_q;
    mask_d   = mask_q;
    reload_d = reload_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    wr_s     = 32'h0000_0000;

    if (reload_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == '0) begin
      cnt_d   = reload_q;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q - PRE_W'(1);
      phase_d = phase_q;
    end

    if (bus.EN) begin
      case (bus.SEL)
        2'b00: begin
          wr_s   = apply_op(packed_s, bus.PData_in, bus.OP);
          cs_d   = wr_s[CS_W-1:0];
          led_d  = wr_s[CS_W +: LED_W];
          gpio_d = wr_s[CS_W+LED_W +: GPIO_W];
        end
        2'b01: begin
          wr_s   = apply_op(32'(mask_q), bus.PData_in, bus.OP);
          mask_d = wr_s[LED_W-1:0];
        end
        2'b10: begin
          // A reload write restarts the blink cycle from the off phase
          wr_s     = apply_op(32'(reload_q), bus.PData_in, bus.OP);
          reload_d = wr_s[PRE_W-1:0];
          cnt_d    = wr_s[PRE_W-1:0];
          phase_d  = 1'b0;
        end
        default: begin
          wr_s = 32'h0000_0000;
        end
      endcase
    end else begin
      wr_s = 32'h0000_0000;
    end
  end

  // Readback of the selected target; LED field shows the register, not the gated pins
  always_comb begin
    case (bus.SEL)
      2'b00:   bus.PData_out = packed_s;
      2'b01:   bus.PData_out = 32'(mask_q);
      2'b10:   bus.PData_out = 32'(reload_q);
      2'b11:   bus.PData_out = {7'b000_0000, phase_q, cnt_ext_s};
      default: bus.PData_out = 32'h0000_0000;
    endcase
  end

  assign bus.counter_set = cs_q;
  assign bus.GPIOf0      = gpio_q;
  assign bus.LED_out     = ~(led_q & ~(mask_q & {LED_W{phase_q}}));

endmodule
